gyro_spi_reader: RTL and testbench
==================================

# gyro_spi_reader

Periodic SPI master that reads the 3-axis gyro rate registers from the IMU, removes a power-up bias estimate and presents signed 16-bit rates to the gyro integration stage. It sits directly upstream of the pitch/roll/yaw integrator, driving that stage's gx/gy/gz inputs. It owns the IMU pins, the sample timer and the bias calibration.

## Interface
- CLK_DIV, 50: clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz); ≥1
- SAMPLE_PERIOD, 100000: clk cycles between transaction starts (1 kHz)
- GYRO_ADDR, 7'h43: first register address (GYRO_XOUT_H); auto-increment burst
- CAL_LOG2, 8: log2 of calibration frame count (256)

Ports:
- clk_100mhz  in  1  system clock; all logic on its rising edge
- rst_in  in  1  synchronous, active-high reset
- miso_in  in  1  IMU serial data out
- sclk_out  out  1  SPI clock, mode 0 (idle low)
- mosi_out  out  1  SPI data to IMU
- cs_n_out  out  1  IMU chip select, active low
- gx, gy, gz  out  16 each  bias-corrected signed rates
- valid_out  out  1  one-cycle pulse: gx/gy/gz updated
- calibrated_out  out  1  level: bias estimate complete
- overrun_out  out  1  sticky: a sample tick was dropped

## Operation
- Reset values: sclk_out 0, mosi_out 0, cs_n_out 1, gx/gy/gz 0, valid_out 0, calibrated_out 0, overrun_out 0; timer, frame counter, accumulators, bias cleared; state IDLE.
- Sample timer free-runs 0..SAMPLE_PERIOD-1, wraps; tick when count == SAMPLE_PERIOD-1.
- Tick in IDLE: go to CS_SETUP next cycle. Tick in any other state: ignored, overrun_out set to 1 (held until reset).
- States: IDLE -> CS_SETUP (CLK_DIV cycles) -> SHIFT (56 bits × 2·CLK_DIV cycles) -> CS_HOLD (CLK_DIV cycles) -> UPDATE (1 cycle) -> IDLE.
- Frame: 56 bits, MSB first. Byte 0 on MOSI = {1'b1 (read), GYRO_ADDR}; bytes 1..6 MOSI 0, MISO captured as X_H, X_L, Y_H, Y_L, Z_H, Z_L.
- MOSI changes at CS_SETUP entry and on each SCLK falling edge; MISO sampled on each SCLK rising edge.
- Calibration: first 2^CAL_LOG2 frames after reset summed per axis into signed (16+CAL_LOG2)-bit accumulators; no valid_out during calibration, gx/gy/gz stay 0. On UPDATE of the last calibration frame: bias = acc >>> CAL_LOG2 (arithmetic), calibrated_out -> 1; that frame produces no output.
- Post-calibration UPDATE: out = raw − bias in 17-bit signed, saturated to [−32768, 32767]; gx/gy/gz registered, valid_out high that cycle.
- Calibration runs once per reset; bias then fixed.

## Timing
- Tick at cycle T−1 -> cs_n_out falls at T (first CS_SETUP cycle).
- SCLK rises at T+(2k+1)·CLK_DIV, falls at T+(2k+2)·CLK_DIV, k = 0..55.
- cs_n_out rises at T+113·CLK_DIV (UPDATE cycle); gx/gy/gz and valid_out change in that same cycle; IDLE from T+113·CLK_DIV+1.
- Minimum non-overrunning SAMPLE_PERIOD: 113·CLK_DIV+2.
- Reset mid-frame: next cycle pins return to idle values (cs_n 1, sclk 0, mosi 0), all outputs to reset values, calibration restarts from frame 0.
- Tick coinciding with UPDATE: dropped, overrun_out set.

## Test plan
Bench params CLK_DIV=2, SAMPLE_PERIOD=400, CAL_LOG2=2; SPI slave model returns programmable 6 bytes.
- Framing: release reset -> cs_n falls cycle 400, MOSI first byte 0xC3, 56 SCLK rising edges, cs_n rises cycle 626, no valid_out.
- Calibration: 4 frames X=0x0010, Y=0xFFF0, Z=0x0004 -> calibrated_out 1 at 4th UPDATE, no valid; 5th frame X=0x0110, Y=0xFFF0, Z=0x0004 -> valid_out pulse, gx=0x0100, gy=0, gz=0.
- Saturation: calibrate X=0xFFF0 (bias −16), then raw X=0x7FFF -> gx=0x7FFF; recalibrate X=0x0010, raw X=0x8000 -> gx=0x8000.
- Reset mid-frame: rst_in at T+100 for one cycle -> next cycle cs_n 1, sclk 0, calibrated_out 0; 4 further frames required before first valid_out.
- Overrun: SAMPLE_PERIOD=200 -> frame starts 200, tick at 399 dropped, overrun_out 1 at cycle 400, next frame starts 600.

Source files
------------

// File: rtl/gyro_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gyro_spi_reader
//  Description : Periodic SPI (mode 0) master that burst-reads the three gyro
//                rate registers of the IMU, estimates a power-up bias over the
//                first 2^CAL_LOG2 frames, then emits bias-corrected, saturated
//                signed 16-bit rates to the integration stage.
//  Ports       : clk_100mhz      system clock, rising edge
//                rst_in          synchronous active-high reset
//                miso_in         IMU serial data out
//                sclk_out        SPI clock, idle low
//                mosi_out        SPI data to IMU
//                cs_n_out        IMU chip select, active low
//                gx, gy, gz      bias-corrected signed rates
//                valid_out       one-cycle pulse, gx/gy/gz updated
//                calibrated_out  level, bias estimate complete
//                overrun_out     sticky, a sample tick was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module gyro_spi_reader #(
  parameter int         CLK_DIV       = 50,
  parameter int         SAMPLE_PERIOD = 100000,
  parameter logic [6:0] GYRO_ADDR     = 7'h43,
  parameter int         CAL_LOG2      = 8
) (
  input  logic               clk_100mhz,
  input  logic               rst_in,
  input  logic               miso_in,
  output logic               sclk_out,
  output logic               mosi_out,
  output logic               cs_n_out,
  output logic signed [15:0] gx,
  output logic signed [15:0] gy,
  output logic signed [15:0] gz,
  output logic               valid_out,
  output logic               calibrated_out,
  output logic               overrun_out
);

  localparam int c_timer_w = $clog2(SAMPLE_PERIOD + 1);
  localparam int c_div_w   = $clog2(CLK_DIV + 1);
  localparam int c_acc_w   = 16 + CAL_LOG2;
  localparam int c_cal_w   = CAL_LOG2 + 1;
  localparam int c_cal_n   = 1 << CAL_LOG2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    UPDATE   = 3'd4
  } state_t;

  state_t                     r_state, w_state_next;
  logic   [c_timer_w-1:0]     r_timer;
  logic   [c_div_w-1:0]       r_div;
  logic   [5:0]               r_bit;
  logic                       r_sclk;
  logic                       r_cs_n;
  logic   [7:0]               r_tx;
  logic   [47:0]              r_rx;
  logic   [c_cal_w-1:0]       r_cal_cnt;
  logic                       r_calibrated;
  logic                       r_valid;
  logic                       r_overrun;
  logic signed [c_acc_w-1:0]  r_acc  [3];
  logic signed [15:0]         r_bias [3];
  logic signed [15:0]         r_out  [3];

  logic                       w_tick, w_div_done;
  logic                       w_load, w_rise, w_fall, w_enter_update;
  logic signed [15:0]         w_raw     [3];
  logic signed [c_acc_w-1:0]  w_acc_sum [3];
  logic signed [16:0]         w_diff    [3];
  logic signed [15:0]         w_sat     [3];

  assign w_tick     = (r_timer == c_timer_w'(SAMPLE_PERIOD - 1));
  assign w_div_done = (r_div == c_div_w'(CLK_DIV - 1));

  // Free-running sample timer, independent of the FSM so ticks stay periodic.
  always_ff @(posedge clk_100mhz) begin
    if (rst_in || w_tick) r_timer <= '0;
    else                  r_timer <= r_timer + c_timer_w'(1);
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // SHIFT holds 111 half-periods (high, low, ..., high). The falling edge after
  // the 56th rising edge enters CS_HOLD, whose low half doubles as the last
  // SCLK low phase, so CS_SETUP + SHIFT + CS_HOLD spans 113 half-periods.
  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_rise         = 1'b0;
    w_fall         = 1'b0;
    w_enter_update = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_next = CS_SETUP;
          w_load       = 1'b1;
        end
      end
      CS_SETUP: begin
        if (w_div_done) begin
          w_state_next = SHIFT;
          w_rise       = 1'b1;
        end
      end
      SHIFT: begin
        if (w_div_done) begin
          if (r_sclk) begin
            w_fall = 1'b1;
            if (r_bit == 6'd55) w_state_next = CS_HOLD;
          end else begin
            w_rise = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (w_div_done) begin
          w_state_next   = UPDATE;
          w_enter_update = 1'b1;
        end
      end
      UPDATE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // SPI datapath. Only the command byte carries data on MOSI; zeros follow.
  // The receive register keeps the last 48 sampled bits, which drops byte 0.
  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
      r_cs_n <= 1'b1;
      r_tx   <= '0;
      r_rx   <= '0;
    end else begin
      if (w_div_done || r_state == IDLE || r_state == UPDATE) r_div <= '0;
      else                                                    r_div <= r_div + c_div_w'(1);
      if (w_rise) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[46:0], miso_in};
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        r_tx   <= {r_tx[6:0], 1'b0};
        r_bit  <= r_bit + 6'd1;
      end
      if (w_load) begin
        r_tx  <= {1'b1, GYRO_ADDR};
        r_bit <= '0;
      end
      r_cs_n <= !(w_state_next == CS_SETUP || w_state_next == SHIFT ||
                  w_state_next == CS_HOLD);
    end
  end

  // Per-axis arithmetic: raw order in the burst is X, Y, Z (high byte first).
  // Saturation: a 17-bit difference overflows 16 bits when its top two bits differ.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_raw[i]     = r_rx[47 - 16*i -: 16];
      w_acc_sum[i] = r_acc[i] + c_acc_w'(w_raw[i]);
      w_diff[i]    = 17'(w_raw[i]) - 17'(r_bias[i]);
      if (w_diff[i][16] != w_diff[i][15]) w_sat[i] = w_diff[i][16] ? 16'sh8000 : 16'sh7FFF;
      else                                w_sat[i] = w_diff[i][15:0];
    end
  end

  // Results are registered on the edge entering UPDATE so they appear in the
  // same cycle as the chip-select release.
  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      r_cal_cnt    <= '0;
      r_calibrated <= 1'b0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_acc[i]  <= '0;
        r_bias[i] <= '0;
        r_out[i]  <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (w_tick && r_state != IDLE) r_overrun <= 1'b1;
      if (w_enter_update) begin
        if (!r_calibrated) begin
          r_cal_cnt <= r_cal_cnt + c_cal_w'(1);
          for (int i = 0; i < 3; i++) r_acc[i] <= w_acc_sum[i];
          if (r_cal_cnt == c_cal_w'(c_cal_n - 1)) begin
            r_calibrated <= 1'b1;
            for (int i = 0; i < 3; i++) r_bias[i] <= 16'(w_acc_sum[i] >>> CAL_LOG2);
          end
        end else begin
          r_valid <= 1'b1;
          for (int i = 0; i < 3; i++) r_out[i] <= w_sat[i];
        end
      end
    end
  end

  assign sclk_out       = r_sclk;
  assign mosi_out       = r_tx[7];
  assign cs_n_out       = r_cs_n;
  assign gx             = r_out[0];
  assign gy             = r_out[1];
  assign gz             = r_out[2];
  assign valid_out      = r_valid;
  assign calibrated_out = r_calibrated;
  assign overrun_out    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gyro_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gyro_spi_reader
//  Description : Self-checking bench for gyro_spi_reader. One instance with a
//                programmable SPI slave (SAMPLE_PERIOD 400) and one with a
//                short period (200) whose frames overrun the sample timer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gyro_spi_reader;

  logic        clk_100mhz = 1'b0;
  logic        rst_in;
  logic        miso = 1'b0;
  logic        sclk, mosi, cs_n, valid, calibrated, overrun;
  logic [15:0] gx, gy, gz;
  logic        sclk2, mosi2, cs_n2, valid2, calibrated2, overrun2;
  logic [15:0] gx2, gy2, gz2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  gyro_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(400), .GYRO_ADDR(7'h43), .CAL_LOG2(2)) dut (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .miso_in(miso),
    .sclk_out(sclk), .mosi_out(mosi), .cs_n_out(cs_n),
    .gx(gx), .gy(gy), .gz(gz), .valid_out(valid),
    .calibrated_out(calibrated), .overrun_out(overrun)
  );

  gyro_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .GYRO_ADDR(7'h43), .CAL_LOG2(2)) dut_ovr (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .miso_in(1'b0),
    .sclk_out(sclk2), .mosi_out(mosi2), .cs_n_out(cs_n2),
    .gx(gx2), .gy(gy2), .gz(gz2), .valid_out(valid2),
    .calibrated_out(calibrated2), .overrun_out(overrun2)
  );

  // Cycle 0 is the cycle following the last reset edge.
  always @(posedge clk_100mhz) cyc <= rst_in ? 0 : cyc + 1;

  // SPI slave: loads {cmd byte slot, 6 data bytes} on CS fall, advances on SCLK
  // fall. Also records MOSI at SCLK rises and counts valid pulses.
  logic [47:0] slave_data = '0;
  logic [55:0] s_shift    = '0;
  logic        cs_prev    = 1'b1;
  logic        sclk_prev  = 1'b0;
  int          n_rise     = 0;
  int          n_valid    = 0;
  logic [7:0]  mosi_byte  = '0;

  always @(negedge clk_100mhz) begin
    cs_prev   <= cs_n;
    sclk_prev <= sclk;
    if (valid) n_valid <= n_valid + 1;
    if (cs_prev && !cs_n) begin
      s_shift   <= {8'h00, slave_data};
      miso      <= 1'b0;
      n_rise    <= 0;
      mosi_byte <= '0;
    end else if (!cs_n && sclk_prev && !sclk) begin
      s_shift <= s_shift << 1;
      miso    <= s_shift[54];
    end
    if (!sclk_prev && sclk) begin
      n_rise <= n_rise + 1;
      if (n_rise < 8) mosi_byte <= {mosi_byte[6:0], mosi};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(negedge clk_100mhz);
      guard++;
    end while (cyc != n && guard < 5000);
    if (cyc != n) check_eq("wait_timeout", cyc, n);
  endtask

  // Pulse reset for one cycle from a negedge; returns in cycle 0.
  task automatic pulse_reset();
    rst_in = 1'b1;
    @(negedge clk_100mhz);
    rst_in = 1'b0;
  endtask

  int vbase;

  initial begin
    // Reset state
    rst_in     = 1'b1;
    slave_data = {16'h0010, 16'hFFF0, 16'h0004};
    repeat (3) @(negedge clk_100mhz);
    check_eq("rst_cs_n", cs_n, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_gx", gx, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_cal", calibrated, 0);
    check_eq("rst_ovr", overrun, 0);
    rst_in = 1'b0;
    vbase  = n_valid;

    // Framing of the first frame, and the overrunning instance alongside it
    wait_cyc(200); check_eq("ovr_cs_start", cs_n2, 0);
    wait_cyc(399); check_eq("cs_before", cs_n, 1); check_eq("ovr_before", overrun2, 0);
    wait_cyc(400); check_eq("cs_fall", cs_n, 0); check_eq("ovr_set", overrun2, 1);
                   check_eq("mosi_first", mosi, 1);
    wait_cyc(401); check_eq("sclk_setup", sclk, 0);
    wait_cyc(402); check_eq("sclk_rise0", sclk, 1);
    wait_cyc(404); check_eq("sclk_fall0", sclk, 0);
    wait_cyc(599); check_eq("ovr_cs_idle", cs_n2, 1);
    wait_cyc(600); check_eq("ovr_cs_next", cs_n2, 0);
    wait_cyc(625); check_eq("cs_hold", cs_n, 0);
    wait_cyc(626); check_eq("cs_rise", cs_n, 1);
                   check_eq("n_rise", n_rise, 56);
                   check_eq("mosi_cmd", mosi_byte, 8'hC3);
                   check_eq("cal_f0", calibrated, 0);
                   check_eq("valid_f0", valid, 0);

    // Calibration completes on the 4th UPDATE, then one corrected sample
    wait_cyc(1825); check_eq("cal_before", calibrated, 0);
    wait_cyc(1826); check_eq("cal_done", calibrated, 1);
                    check_eq("valid_cal", n_valid - vbase, 0);
    slave_data = {16'h0110, 16'hFFF0, 16'h0004};
    wait_cyc(2226); check_eq("valid_pulse", valid, 1);
                    check_eq("gx_basic", gx, 16'h0100);
                    check_eq("gy_basic", gy, 16'h0000);
                    check_eq("gz_basic", gz, 16'h0000);
    wait_cyc(2227); check_eq("valid_drop", valid, 0);
                    check_eq("valid_count", n_valid - vbase, 1);

    // Reset in the middle of frame 5 (started at 2400)
    wait_cyc(2500); check_eq("mid_cs", cs_n, 0);
    pulse_reset();
    check_eq("mid_rst_cs_n", cs_n, 1);
    check_eq("mid_rst_sclk", sclk, 0);
    check_eq("mid_rst_mosi", mosi, 0);
    check_eq("mid_rst_cal", calibrated, 0);
    check_eq("mid_rst_gx", gx, 0);
    vbase = n_valid;

    // Recalibration with biases X=-16, Y=0x1234, Z=-32768, then saturating sample
    slave_data = {16'hFFF0, 16'h1234, 16'h8000};
    wait_cyc(1425); check_eq("recal_pending", calibrated, 0);
    wait_cyc(1826); check_eq("recal_done", calibrated, 1);
                    check_eq("recal_no_valid", n_valid - vbase, 0);
    slave_data = {16'h7FFF, 16'h1000, 16'h7FFF};
    wait_cyc(2226); check_eq("sat_valid", valid, 1);
                    check_eq("gx_sat_pos", gx, 16'h7FFF);
                    check_eq("gy_neg", gy, 16'hFDCC);
                    check_eq("gz_sat_pos", gz, 16'h7FFF);

    // Recalibrate with Z averaging to floor(-1.5) = -2, then negative saturation
    wait_cyc(2230);
    pulse_reset();
    check_eq("rst2_cal", calibrated, 0);
    check_eq("rst2_gx", gx, 0);
    for (int k = 0; k < 4; k++) begin
      slave_data = {16'h0010, 16'h7FFF, (k % 2 == 1) ? 16'hFFFE : 16'hFFFF};
      wait_cyc(400 * (k + 1) + 226);
    end
    check_eq("cal3_done", calibrated, 1);
    slave_data = {16'h8000, 16'h8000, 16'h0000};
    wait_cyc(2226); check_eq("neg_valid", valid, 1);
                    check_eq("gx_sat_neg", gx, 16'h8000);
                    check_eq("gy_sat_neg", gy, 16'h8000);
                    check_eq("gz_floor_bias", gz, 16'h0002);
                    check_eq("ovr_main_clear", overrun, 0);
                    check_eq("ovr_sticky", overrun2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
